// File: rtl/vga_intr_pkg.sv
// Shared register offsets, AXI response codes and byte-strobe helper for the
// VGA buffer interrupt controller.
package vga_intr_pkg;

  localparam logic [4:0] GIER_OFS = 5'h00;
  localparam logic [4:0] IER_OFS  = 5'h04;
  localparam logic [4:0] ISR_OFS  = 5'h08;
  localparam logic [4:0] IAR_OFS  = 5'h0C;
  localparam logic [4:0] IPR_OFS  = 5'h10;

  typedef enum logic [1:0] {
    OKAY   = 2'b00,
    EXOKAY = 2'b01,
    SLVERR = 2'b10,
    DECERR = 2'b11
  } axi_resp_t;

  function automatic logic [31:0] apply_wstrb(input logic [31:0] old_val,
                                              input logic [31:0] wdata,
                                              input logic [3:0]  wstrb);
    logic [31:0] v;
    v = old_val;
    for (int b = 0; b < 4; b++) begin
      if (wstrb[b]) v[8*b +: 8] = wdata[8*b +: 8];
    end
    return v;
  endfunction

endpackage

// File: rtl/vga_intr_src_edge.sv
// Per-source rising-edge detector feeding a sticky status latch; a new edge
// beats a simultaneous clear so no event is lost.
module vga_intr_src_edge #(
  parameter int N = 1
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic [N-1:0] i_src,
  input  logic [N-1:0] i_clear,
  output logic [N-1:0] o_status
);

  logic [N-1:0] r_src_q;
  logic [N-1:0] r_status;
  logic [N-1:0] w_event;

  assign w_event  = i_src & ~r_src_q;
  assign o_status = r_status;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_src_q  <= '0;
      r_status <= '0;
    end else begin
      r_src_q  <= i_src;
      r_status <= (r_status & ~i_clear) | w_event;
    end
  end

endmodule

// File: rtl/vga_buffer_intr_ctrl.sv
// AXI4-Lite interrupt controller for the VGA buffer (GIER/IER/ISR/IAR/IPR).
// Define VGA_INTR_EDGE_IRQ_EN for a one-cycle irq pulse instead of a level.
module vga_buffer_intr_ctrl
  import vga_intr_pkg::*;
#(
  parameter int C_S_AXI_DATA_WIDTH = 32,
  parameter int C_S_AXI_ADDR_WIDTH = 5,
  parameter int C_NUM_OF_INTR      = 1,
  parameter int C_IRQ_ACTIVE_STATE = 1
) (
  input  logic                            ACLK,
  input  logic                            ARESETN,
  input  logic [C_NUM_OF_INTR-1:0]        intr_src,
  input  logic [C_S_AXI_ADDR_WIDTH-1:0]   S_AXI_AWADDR,
  input  logic [2:0]                      S_AXI_AWPROT,
  input  logic                            S_AXI_AWVALID,
  output logic                            S_AXI_AWREADY,
  input  logic [C_S_AXI_DATA_WIDTH-1:0]   S_AXI_WDATA,
  input  logic [C_S_AXI_DATA_WIDTH/8-1:0] S_AXI_WSTRB,
  input  logic                            S_AXI_WVALID,
  output logic                            S_AXI_WREADY,
  output logic [1:0]                      S_AXI_BRESP,
  output logic                            S_AXI_BVALID,
  input  logic                            S_AXI_BREADY,
  input  logic [C_S_AXI_ADDR_WIDTH-1:0]   S_AXI_ARADDR,
  input  logic [2:0]                      S_AXI_ARPROT,
  input  logic                            S_AXI_ARVALID,
  output logic                            S_AXI_ARREADY,
  output logic [C_S_AXI_DATA_WIDTH-1:0]   S_AXI_RDATA,
  output logic [1:0]                      S_AXI_RRESP,
  output logic                            S_AXI_RVALID,
  input  logic                            S_AXI_RREADY,
  output logic                            irq
);

  localparam int   N         = C_NUM_OF_INTR;
  localparam logic LP_IRQ_ON = (C_IRQ_ACTIVE_STATE != 0);

  logic          r_aw_held, r_w_held;
  logic [2:0]    r_aw_word;
  logic [31:0]   r_wdata;
  logic [3:0]    r_wstrb;
  logic          r_bvalid, r_rvalid;
  logic [31:0]   r_rdata;
  logic          r_gier;
  logic [N-1:0]  r_ier;
  logic          r_irq;

  logic          w_wr_en, w_agg, w_unused;
  logic [31:0]   w_wr_bits, w_ier_ext, w_ier_new, w_gier_new, w_rd_val;
  logic [N-1:0]  w_isr, w_ipr, w_iar_clear;

  assign S_AXI_AWREADY = ARESETN & ~r_aw_held & ~r_bvalid;
  assign S_AXI_WREADY  = ARESETN & ~r_w_held & ~r_bvalid;
  assign S_AXI_ARREADY = ARESETN & ~r_rvalid;
  assign S_AXI_BVALID  = r_bvalid;
  assign S_AXI_RVALID  = r_rvalid;
  assign S_AXI_RDATA   = r_rdata;
  assign S_AXI_BRESP   = OKAY;
  assign S_AXI_RRESP   = OKAY;

  // Register update happens in the one cycle where both AW and W are held.
  assign w_wr_en    = r_aw_held & r_w_held;
  assign w_wr_bits  = apply_wstrb(32'h0, r_wdata, r_wstrb);
  assign w_ier_new  = apply_wstrb(w_ier_ext, r_wdata, r_wstrb);
  assign w_gier_new = apply_wstrb({31'h0, r_gier}, r_wdata, r_wstrb);
  assign w_iar_clear = (w_wr_en && r_aw_word == IAR_OFS[4:2]) ? w_wr_bits[N-1:0] : '0;
  assign w_ipr = w_isr & r_ier;
  assign w_agg = r_gier & (|w_ipr);

  always_comb begin
    w_ier_ext        = '0;
    w_ier_ext[N-1:0] = r_ier;
  end

  always_ff @(posedge ACLK or negedge ARESETN) begin
    if (!ARESETN) begin
      r_aw_held <= 1'b0;
      r_w_held  <= 1'b0;
      r_aw_word <= '0;
      r_wdata   <= '0;
      r_wstrb   <= '0;
      r_bvalid  <= 1'b0;
    end else begin
      if (S_AXI_AWVALID && S_AXI_AWREADY) begin
        r_aw_held <= 1'b1;
        r_aw_word <= S_AXI_AWADDR[4:2];
      end
      if (S_AXI_WVALID && S_AXI_WREADY) begin
        r_w_held <= 1'b1;
        r_wdata  <= S_AXI_WDATA;
        r_wstrb  <= S_AXI_WSTRB;
      end
      if (w_wr_en) begin
        r_aw_held <= 1'b0;
        r_w_held  <= 1'b0;
        r_bvalid  <= 1'b1;
      end else if (r_bvalid && S_AXI_BREADY) begin
        r_bvalid <= 1'b0;
      end
    end
  end

  always_ff @(posedge ACLK or negedge ARESETN) begin
    if (!ARESETN) begin
      r_gier <= 1'b0;
      r_ier  <= '0;
    end else if (w_wr_en) begin
      case (r_aw_word)
        GIER_OFS[4:2]: r_gier <= w_gier_new[0];
        IER_OFS[4:2]:  r_ier  <= w_ier_new[N-1:0];
        default: ;
      endcase
    end
  end

  vga_intr_src_edge #(.N(N)) u_src_edge (
    .clk      (ACLK),
    .rst_n    (ARESETN),
    .i_src    (intr_src),
    .i_clear  (w_iar_clear),
    .o_status (w_isr)
  );

  always_comb begin
    w_rd_val = '0;
    case (S_AXI_ARADDR[4:2])
      GIER_OFS[4:2]: w_rd_val[0]     = r_gier;
      IER_OFS[4:2]:  w_rd_val[N-1:0] = r_ier;
      ISR_OFS[4:2]:  w_rd_val[N-1:0] = w_isr;
      IPR_OFS[4:2]:  w_rd_val[N-1:0] = w_ipr;
      default: ;
    endcase
  end

  always_ff @(posedge ACLK or negedge ARESETN) begin
    if (!ARESETN) begin
      r_rvalid <= 1'b0;
      r_rdata  <= '0;
    end else if (S_AXI_ARVALID && S_AXI_ARREADY) begin
      r_rvalid <= 1'b1;
      r_rdata  <= w_rd_val;
    end else if (r_rvalid && S_AXI_RREADY) begin
      r_rvalid <= 1'b0;
    end
  end

`ifdef VGA_INTR_EDGE_IRQ_EN
  logic r_agg_q;
  always_ff @(posedge ACLK or negedge ARESETN) begin
    if (!ARESETN) begin
      r_agg_q <= 1'b0;
      r_irq   <= 1'b0;
    end else begin
      r_agg_q <= w_agg;
      r_irq   <= w_agg & ~r_agg_q;
    end
  end
`else
  always_ff @(posedge ACLK or negedge ARESETN) begin
    if (!ARESETN) r_irq <= 1'b0;
    else          r_irq <= w_agg;
  end
`endif

  assign irq = r_irq ? LP_IRQ_ON : ~LP_IRQ_ON;

  assign w_unused = ^{S_AXI_AWPROT, S_AXI_ARPROT, S_AXI_AWADDR[1:0], S_AXI_ARADDR[1:0],
                      w_wr_bits, w_ier_new, w_gier_new};

endmodule
